// File: rtl/ripple_carry_adder_64bit_if.sv
// ripple_carry_adder_64bit_if: operand bus (in1, in2, c_in from master; registered sum, c_out back from slave)
interface ripple_carry_adder_64bit_if;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        c_in;
  logic [63:0] sum;
  logic        c_out;
  modport master (output in1, in2, c_in, input sum, c_out);
  modport slave (input in1, in2, c_in, output sum, c_out);
endinterface

// File: rtl/ripple_carry_adder_64bit.sv
// ripple_carry_adder_64bit: registered 64-bit ripple adder of sixteen 4-bit blocks; clk, async active-low rst_n, bus slave (in1, in2, c_in -> sum, c_out)
module rca_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_p;
  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

module rca_block4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [4:0] w_c;
  assign w_c[0] = i_ci;
  assign o_co   = w_c[4];
  for (genvar i = 0; i < 4; i++) begin : g_fa
    rca_full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_ci(w_c[i]),
      .o_s (o_s[i]),
      .o_co(w_c[i+1])
    );
  end
endmodule

module ripple_carry_adder_64bit (
  input  logic                                clk,
  input  logic                                rst_n,
  ripple_carry_adder_64bit_if.slave           bus
);
  logic [16:0] w_c;
  logic [63:0] w_sum;
  logic [63:0] r_sum;
  logic        r_c_out;
  assign w_c[0] = bus.c_in;
  for (genvar b = 0; b < 16; b++) begin : g_blk
    rca_block4 u_blk (
      .i_a (bus.in1[4*b +: 4]),
      .i_b (bus.in2[4*b +: 4]),
      .i_ci(w_c[b]),
      .o_s (w_sum[4*b +: 4]),
      .o_co(w_c[b+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_c_out <= w_c[16];
    end
  end
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;
endmodule

// File: tb/tb_ripple_carry_adder_64bit.sv
// tb_ripple_carry_adder_64bit: directed table, random vects vs arithmetic model, hold and async reset sequences
module tb_ripple_carry_adder_64bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ripple_carry_adder_64bit_if bus ();
  ripple_carry_adder_64bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        co;
  } vec_t;
  vec_t tbl[7];
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {64'd0, ci};
  endfunction
  task automatic check(input string name, input logic [63:0] es, input logic ec);
    n_cmp++;
    if (bus.sum !== es || bus.c_out !== ec) begin
      n_bad++;
      $display("FAIL %s: got sum=%h c_out=%b, expected sum=%h c_out=%b", name, bus.sum, bus.c_out, es, ec);
    end
  endtask
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ci);
    @(negedge clk);
    bus.in1  = a;
    bus.in2  = b;
    bus.c_in = ci;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [64:0] exp;
    logic [63:0] a, b;
    logic        ci;
    tbl[0] = '{"req023", 64'd12345678912345, 64'd98765432198765, 1'b0, 64'd111111111111110, 1'b0};
    tbl[1] = '{"req024", 64'd12345678912345, 64'd98765432198765, 1'b1, 64'd111111111111111, 1'b0};
    tbl[2] = '{"req025", 64'd18446744073709551610, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[3] = '{"req026_wrap", 64'd18446744073709551610, 64'd6, 1'b0, 64'd0, 1'b1};
    tbl[4] = '{"req026_cin", 64'd18446744073709551610, 64'd6, 1'b1, 64'd1, 1'b1};
    tbl[5] = '{"req027", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
    tbl[6] = '{"max_plus_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    bus.in1  = 64'h1234;
    bus.in2  = 64'h5678;
    bus.c_in = 1'b1;
    #3;
    check("reset_init", 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_clk", 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 64'd0, 1'b0);
    @(posedge clk);
    #1;
    check("first_capture", 64'h68AD, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci);
      check(tbl[i].name, tbl[i].s, tbl[i].co);
    end
    drive(64'd12345678912345, 64'd98765432198765, 1'b0);
    bus.in1  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in2  = 64'd1;
    bus.c_in = 1'b1;
    #2;
    check("hold_between_edges", 64'd111111111111110, 1'b0);
    for (int i = 0; i < 300; i++) begin
      a  = {$urandom(), $urandom()};
      ci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = ~a;
        1: b = 64'd1 << $urandom_range(0, 63);
        default: b = {$urandom(), $urandom()};
      endcase
      exp = model(a, b, ci);
      drive(a, b, ci);
      check($sformatf("rand%0d", i), exp[63:0], exp[64]);
    end
    drive(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b1);
    check("pre_reset_load", 64'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 64'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_discards", 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("release_waits_edge", 64'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reappear_after_edge", 64'd1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder_64bit.md
RIPPLE_CARRY_ADDER_64BIT -- requirements
Module: ripple_carry_adder_64bit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 64 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in1  input  64  first unsigned addend.
REQ-005 in2  input  64  second unsigned addend.
REQ-006 c_in  input  1  carry into bit 0.
REQ-007 sum  output  64  registered sum bits [63:0].
REQ-008 c_out  output  1  registered carry out of bit 63.

Function
REQ-009 The adder SHALL compute {c_out, sum} = in1 + in2 + c_in as a 65-bit unsigned result, with no saturation and no signed interpretation.
REQ-010 The datapath SHALL be a ripple chain of 64 one-bit full-adder cells, carry propagating from bit 0 to bit 63, with no carry-lookahead or carry-select logic.
REQ-011 Each full-adder cell SHALL produce s = a XOR b XOR ci and co = (a AND b) OR (ci AND (a XOR b)).
REQ-012 Cells SHALL be grouped hierarchically into 4-bit ripple blocks, chained 16 times, with block carry-out feeding the next block's carry-in.
REQ-013 in1, in2 and c_in SHALL be sampled on every rising clk edge while rst_n is high.
REQ-014 sum and c_out SHALL reflect the sampled operands after exactly 1 clock of latency, i.e. updated on the same edge that samples them.
REQ-015 Outputs SHALL hold their value between edges regardless of input changes.
REQ-016 Overflow SHALL wrap modulo 2^64 in sum, with the carry reported only on c_out.
REQ-017 c_in = 1 SHALL add exactly one to the result, including propagation across all 64 bits.
REQ-018 The full 64-bit carry path SHALL be the sole timing path and SHALL settle within one clk period.
REQ-019 There SHALL be no handshake, valid or ready signals; every clock edge is a new operation.

Reset
REQ-020 While rst_n = 0, sum SHALL be 64'd0 and c_out SHALL be 0, taking effect immediately and independent of clk.
REQ-021 A reset asserted mid-operation SHALL discard the pending result; no stale value SHALL appear after release.
REQ-022 After rst_n rises, the first capture SHALL occur on the next rising clk edge.

Verification
REQ-023 in1=12345678912345, in2=98765432198765, c_in=0 -> after 1 clk: sum=111111111111110, c_out=0.
REQ-024 Same operands, c_in=1 -> sum=111111111111111, c_out=0.
REQ-025 in1=18446744073709551610, in2=5, c_in=0 -> sum=18446744073709551615 (all ones), c_out=0.
REQ-026 in1=18446744073709551610, in2=6, c_in=0 -> sum=0, c_out=1 (wrap); with c_in=1 -> sum=1, c_out=1.
REQ-027 in1=all ones, in2=0, c_in=1 -> sum=0, c_out=1 (full-length ripple).
REQ-028 Load any nonzero result, then pull rst_n low between clock edges -> sum=0 and c_out=0 immediately; hold inputs and release rst_n -> result reappears only after the next rising edge.
